// File: rtl/c3aibadapt_cmn_cp_dist_pair_pl_pkg.sv
// Shared CP distribution definitions: depth clamping and settle-counter reload rules.
package c3aibadapt_cmn_cp_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_CFG,
    CNT_CHG,
    CNT_DEC
  } cnt_op_e;

  localparam int unsigned CNT_SETTLED = 0;

  function automatic int unsigned clamp_depth(input int unsigned depth,
                                              input int unsigned max_depth);
    return (depth > max_depth) ? max_depth : depth;
  endfunction

  // The edge that accepts a change already loads stage 1, so one fewer edge remains.
  function automatic int unsigned chg_reload(input int unsigned depth);
    return (depth == 0) ? CNT_SETTLED : depth - 1;
  endfunction

endpackage

// File: rtl/c3aibadapt_cmn_cp_dist_pair_pl_if.sv
// CP distribution bundle: data enable, sources, CRAM controls and per-direction outputs.
interface c3aibadapt_cmn_cp_dist_pair_pl_if #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned MAX_DEPTH = 4,
  parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
);
  logic               data_enable;
  logic [WIDTH-1:0]   master_in;
  logic [WIDTH-1:0]   us_in;
  logic [WIDTH-1:0]   ds_in;
  logic               r_us_master;
  logic               r_ds_master;
  logic [DEPTH_W-1:0] r_us_depth;
  logic [DEPTH_W-1:0] r_ds_depth;
  logic [WIDTH-1:0]   us_out;
  logic [WIDTH-1:0]   ds_out;
  logic [WIDTH-1:0]   us_tap;
  logic [WIDTH-1:0]   ds_tap;
  logic               us_settled;
  logic               ds_settled;

  modport master (
    output data_enable, master_in, us_in, ds_in,
    output r_us_master, r_ds_master, r_us_depth, r_ds_depth,
    input  us_out, ds_out, us_tap, ds_tap, us_settled, ds_settled
  );

  modport slave (
    input  data_enable, master_in, us_in, ds_in,
    input  r_us_master, r_ds_master, r_us_depth, r_ds_depth,
    output us_out, ds_out, us_tap, ds_tap, us_settled, ds_settled
  );
endinterface

// File: rtl/c3aibadapt_cmn_cp_dist_pair_pl_dist.sv
// One CP distribution direction: source select, enable-qualified pipeline, settle counter.
module c3aibadapt_cmn_cp_dist_pl #(
  parameter int unsigned    WIDTH     = 1,
  parameter int unsigned    MAX_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned    DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               i_data_enable,
  input  logic [WIDTH-1:0]   i_master,
  input  logic [WIDTH-1:0]   i_nbr,
  input  logic               i_master_sel,
  input  logic [DEPTH_W-1:0] i_depth,
  output logic [WIDTH-1:0]   o_out,
  output logic [WIDTH-1:0]   o_tap,
  output logic               o_settled
);
  import c3aibadapt_cmn_cp_pkg::*;

  logic [WIDTH-1:0]   w_src;
  logic [DEPTH_W-1:0] w_depth;
  logic [DEPTH_W:0]   w_cfg;
  logic [DEPTH_W:0]   r_cfg_q;
  logic [WIDTH-1:0]   r_stage [1:MAX_DEPTH];
  logic [WIDTH-1:0]   r_last_src;
  logic [DEPTH_W-1:0] r_cnt;
  logic [DEPTH_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   w_tap;
  logic               w_cfg_chg;
  logic               w_src_chg;
  cnt_op_e            w_cnt_op;

  assign w_src     = i_master_sel ? i_master : i_nbr;
  assign w_depth   = DEPTH_W'(clamp_depth(32'(i_depth), MAX_DEPTH));
  assign w_cfg     = {i_master_sel, w_depth};
  assign w_cfg_chg = (w_cfg != r_cfg_q);
  assign w_src_chg = i_data_enable && (w_src != r_last_src);

  always_comb begin
    w_tap = w_src;
    for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
      if (32'(w_depth) == k) w_tap = r_stage[k];
    end
  end

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_cfg_chg)                            w_cnt_op = CNT_CFG;
    else if (w_src_chg)                       w_cnt_op = CNT_CHG;
    else if (i_data_enable && r_cnt != '0)    w_cnt_op = CNT_DEC;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case (w_cnt_op)
      CNT_CFG:  w_cnt_nxt = w_depth;
      CNT_CHG:  w_cnt_nxt = DEPTH_W'(chg_reload(32'(w_depth)));
      CNT_DEC:  w_cnt_nxt = r_cnt - 1'b1;
      default:  w_cnt_nxt = r_cnt;
    endcase
  end

  // cfg_q tracks the live CSRs even in reset so deassertion never looks like a config change.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int unsigned k = 1; k <= MAX_DEPTH; k++) r_stage[k] <= RESET_VAL;
      r_last_src <= RESET_VAL;
      r_cnt      <= '0;
      r_cfg_q    <= w_cfg;
    end else begin
      r_cfg_q <= w_cfg;
      r_cnt   <= w_cnt_nxt;
      if (i_data_enable) begin
        r_stage[1] <= w_src;
        for (int unsigned k = 2; k <= MAX_DEPTH; k++) r_stage[k] <= r_stage[k-1];
        r_last_src <= w_src;
      end
    end
  end

  assign o_out     = w_tap;
  assign o_tap     = w_tap;
  assign o_settled = (r_cnt == '0);

endmodule

// File: rtl/c3aibadapt_cmn_cp_dist_pair_pl.sv
// Bidirectional CP distribution node: two independent single-direction pipelines.
module c3aibadapt_cmn_cp_dist_pair_pl #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      MAX_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             srst,
  c3aibadapt_cmn_cp_dist_pair_pl_if.slave  cp
);
  import c3aibadapt_cmn_cp_pkg::*;

  c3aibadapt_cmn_cp_dist_pl #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .RESET_VAL (RESET_VAL),
    .DEPTH_W   (DEPTH_W)
  ) adapt_cmn_cp_dist_pl_dwn (
    .clk           (clk),
    .srst          (srst),
    .i_data_enable (cp.data_enable),
    .i_master      (cp.master_in),
    .i_nbr         (cp.us_in),
    .i_master_sel  (cp.r_ds_master),
    .i_depth       (cp.r_ds_depth),
    .o_out         (cp.ds_out),
    .o_tap         (cp.ds_tap),
    .o_settled     (cp.ds_settled)
  );

  c3aibadapt_cmn_cp_dist_pl #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAX_DEPTH),
    .RESET_VAL (RESET_VAL),
    .DEPTH_W   (DEPTH_W)
  ) adapt_cmn_cp_dist_pl_up (
    .clk           (clk),
    .srst          (srst),
    .i_data_enable (cp.data_enable),
    .i_master      (cp.master_in),
    .i_nbr         (cp.ds_in),
    .i_master_sel  (cp.r_us_master),
    .i_depth       (cp.r_us_depth),
    .o_out         (cp.us_out),
    .o_tap         (cp.us_tap),
    .o_settled     (cp.us_settled)
  );

endmodule
